// File: rtl/fixed_q9_pkg.sv
// Shared Q4.9 constants, FSM state type and helpers.
// FIXED_DIV_ROUND_EN selects the rounding divider (one guard quotient bit).
package fixed_q9_pkg;

    localparam int WIDTH    = 13;
    localparam int FRAC     = 9;
    localparam int QMAX     = 4095;
    localparam int NB_TRUNC = 22;
    localparam int NB_ROUND = 23;

`ifdef FIXED_DIV_ROUND_EN
    localparam int NB = NB_ROUND;
`else
    localparam int NB = NB_TRUNC;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Widened so that -4096 maps to +4096.
    function automatic logic [WIDTH:0] mag_of(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] x;
        x = {v[WIDTH-1], v};
        return v[WIDTH-1] ? -x : x;
    endfunction

endpackage

// File: rtl/fixed_div_q9_if.sv
// Operand/result handshake bundle for the Q4.9 divider.
interface fixed_div_q9_if
    import fixed_q9_pkg::*;
();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] num;
    logic [WIDTH-1:0] den;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quot;
    logic             ovf;
    logic             dz;

    modport master (
        output in_valid, num, den, out_ready,
        input  in_ready, out_valid, quot, ovf, dz
    );

    modport slave (
        input  in_valid, num, den, out_ready,
        output in_ready, out_valid, quot, ovf, dz
    );
endinterface

// File: rtl/q9_sat_sign.sv
// Saturates a magnitude quotient to +/-QMAX and reapplies the sign.
module q9_sat_sign
    import fixed_q9_pkg::*;
#(
    parameter int QW = 22
) (
    input  logic [QW-1:0]    q_mag,
    input  logic             sign,
    input  logic             num_zero,
    input  logic             den_zero,
    output logic [WIDTH-1:0] quot,
    output logic             ovf,
    output logic             dz
);
    localparam logic [WIDTH-2:0] MAG_MAX = QMAX[WIDTH-2:0];

    logic [WIDTH-2:0] mag;

    always_comb begin
        mag = '0;
        ovf = 1'b0;
        // A zero numerator wins even over a zero denominator.
        if (num_zero) begin
            mag = '0;
        end else if (den_zero) begin
            mag = MAG_MAX;
            ovf = 1'b1;
        end else if (q_mag > QW'(QMAX)) begin
            mag = MAG_MAX;
            ovf = 1'b1;
        end else begin
            mag = q_mag[WIDTH-2:0];
        end
        quot = sign ? -{1'b0, mag} : {1'b0, mag};
        dz   = den_zero;
    end
endmodule

// File: rtl/fixed_div_q9.sv
// Sequential restoring Q4.9 divider, one quotient bit per cycle.
// FIXED_DIV_ROUND_EN: extra guard bit, round half away from zero.
module fixed_div_q9
    import fixed_q9_pkg::*;
(
    input logic           clk,
    input logic           rst,
    fixed_div_q9_if.slave bus
);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_CALC = CALC;
    localparam logic [1:0] S_DONE = DONE;
    localparam int RW = WIDTH + 1;
    localparam int SH = FRAC + (NB - NB_TRUNC);
    localparam logic [4:0] CNT_END = 5'(NB);

    logic [1:0]       state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic             nz_q, nz_d;
    logic             dzf_q, dzf_d;
    logic [RW-1:0]    dmag_q, dmag_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [NB-1:0]    dvd_q, dvd_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic             ovf_q, ovf_d;
    logic             dz_q, dz_d;

    logic [RW:0]      rem_sh;
    logic             q_bit;
    logic [NB-1:0]    mag_w;
    logic [WIDTH-1:0] sat_quot;
    logic             sat_ovf;
    logic             sat_dz;

    // Dividend shifts out MSB-first; quotient bits fill in from the LSB.
    assign rem_sh = {rem_q, dvd_q[NB-1]};
    assign q_bit  = rem_sh >= {1'b0, dmag_q};

`ifdef FIXED_DIV_ROUND_EN
    assign mag_w = {1'b0, dvd_q[NB-1:1]} + NB'(dvd_q[0]);
`else
    assign mag_w = dvd_q;
`endif

    q9_sat_sign #(.QW(NB)) u_sat (
        .q_mag    (mag_w),
        .sign     (sign_q),
        .num_zero (nz_q),
        .den_zero (dzf_q),
        .quot     (sat_quot),
        .ovf      (sat_ovf),
        .dz       (sat_dz)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        nz_d    = nz_q;
        dzf_d   = dzf_q;
        dmag_d  = dmag_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        quot_d  = quot_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                    sign_d  = bus.num[WIDTH-1] ^ bus.den[WIDTH-1];
                    nz_d    = bus.num == '0;
                    dzf_d   = bus.den == '0;
                    dmag_d  = mag_of(bus.den);
                    rem_d   = '0;
                    dvd_d   = NB'(mag_of(bus.num)) << SH;
                end
            end
            S_CALC: begin
                if (cnt_q == CNT_END) begin
                    state_d = S_DONE;
                    quot_d  = sat_quot;
                    ovf_d   = sat_ovf;
                    dz_d    = sat_dz;
                end else begin
                    rem_d = q_bit ? RW'(rem_sh - {1'b0, dmag_q})
                                  : rem_sh[RW-1:0];
                    dvd_d = {dvd_q[NB-2:0], q_bit};
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            nz_q    <= 1'b0;
            dzf_q   <= 1'b0;
            dmag_q  <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            quot_q  <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            nz_q    <= nz_d;
            dzf_q   <= dzf_d;
            dmag_q  <= dmag_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            quot_q  <= quot_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.in_ready  = state_q == S_IDLE;
    assign bus.out_valid = state_q == S_DONE;
    assign bus.quot      = quot_q;
    assign bus.ovf       = ovf_q;
    assign bus.dz        = dz_q;
endmodule
